mem_port_arbiter: RTL

Shares the multicycle processor's single-ported memory between the processor core and a debug/monitor port. The debug port is driven from the board switches or HEX display logic. The block grants one requester at a time, sequences a fixed three-phase access against a memory with one-cycle read latency, and returns data with a one-cycle acknowledge. It sits between the core's memory interface and the memory instance inside the `multicycle` top level.

---
 rtl/mem_port_arb_pkg.sv | 18 +
 rtl/arb_starve_ctr.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg: shared encodings for the memory port arbiter.
// Holds the access-sequencer state encoding and the owner codes that
// appear on the owner output.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_DBG  = 2'b10
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts core grants made while the debug port is waiting
// and raises starve_force once the count reaches STARVE_MAX, so the
// arbiter hands the next contested slot to debug. Only instantiated when
// MEM_PORT_ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr
  import mem_port_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in_idle,
  input  logic dbg_req,
  input  logic core_grant,
  input  logic dbg_grant,
  output logic starve_force
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear when debug is served or stops waiting; count saturating core wins while debug waits.
  always_comb begin
    cnt_d = cnt_q;
    if (dbg_grant || (in_idle && !dbg_req)) begin
      cnt_d = '0;
    end else if (core_grant && dbg_req && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_force = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-ported, one-cycle-read-latency memory
// between the processor core and the debug/monitor port. Each access runs
// IDLE -> ACCESS -> DONE and returns a one-cycle ack plus registered read
// data. Core has fixed priority; a requester is masked during its own ack
// cycle. Defining MEM_PORT_ARB_STARVE_GUARD_EN adds a starvation guard that
// lets debug win after STARVE_MAX consecutive contested core grants.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              acc_we_q, acc_we_d;
  logic              core_ack_q, core_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic in_idle;
  logic core_elig;
  logic dbg_elig;
  logic starve_force;
  logic grant_core;
  logic grant_dbg;

  // A requester whose ack is showing this cycle is ignored until the next IDLE cycle.
  assign in_idle    = (state_q == ST_IDLE);
  assign core_elig  = core_req & ~core_ack_q;
  assign dbg_elig   = dbg_req & ~dbg_ack_q;
  assign grant_core = in_idle & core_elig & ~(dbg_elig & starve_force);
  assign grant_dbg  = in_idle & dbg_elig & ~grant_core;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clock       (clock),
    .reset       (reset),
    .in_idle     (in_idle),
    .dbg_req     (dbg_req),
    .core_grant  (grant_core),
    .dbg_grant   (grant_dbg),
    .starve_force(starve_force)
  );
`else
  assign starve_force = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave IDLE on any grant, then ACCESS and DONE last one cycle each.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_core || grant_dbg) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: latch the winner at grant, drop mem_we after ACCESS, ack and return data from DONE.
  always_comb begin
    owner_d      = owner_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    acc_we_d     = acc_we_q;
    core_ack_d   = 1'b0;
    dbg_ack_d    = 1'b0;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_core) begin
          owner_d     = OWN_CORE;
          mem_addr_d  = core_addr;
          mem_wdata_d = core_wdata;
          mem_we_d    = core_we;
          acc_we_d    = core_we;
        end else if (grant_dbg) begin
          owner_d     = OWN_DBG;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
          mem_we_d    = dbg_we;
          acc_we_d    = dbg_we;
        end
      end
      ST_ACCESS: begin
        mem_we_d = 1'b0;
      end
      ST_DONE: begin
        owner_d = OWN_NONE;
        if (owner_q == OWN_CORE) begin
          core_ack_d = 1'b1;
          if (!acc_we_q) core_rdata_d = mem_rdata;
        end else if (owner_q == OWN_DBG) begin
          dbg_ack_d = 1'b1;
          if (!acc_we_q) dbg_rdata_d = mem_rdata;
        end
      end
      default: begin
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Datapath and handshake registers; reset abandons any in-flight access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWN_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      acc_we_q     <= 1'b0;
      core_ack_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      acc_we_q     <= acc_we_d;
      core_ack_q   <= core_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign owner      = owner_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign core_ack   = core_ack_q;
  assign dbg_ack    = dbg_ack_q;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule
